// File: rtl/log_mult_pkg.sv
// log_mult_pkg: definitions shared by the log-domain adder and the
// antilog (inverse-conversion) stage of the Mitchell log multiplier.
//   kw_w(width)   : characteristic width, $clog2(width)+1
//   prod_w(width) : product width, 2*width
//   s1_payload_t  : stage-1 payload {zero, e, m}. The fields are sized for
//                   the widest supported operand (16 bits). Narrower
//                   configurations zero-extend into them.
package log_mult_pkg;

  function automatic int kw_w(input int width);
    return $clog2(width) + 1;
  endfunction

  function automatic int prod_w(input int width);
    return 2 * width;
  endfunction

  localparam int LM_MAX_WIDTH = 16;
  localparam int LM_E_W       = kw_w(LM_MAX_WIDTH);
  // m is KEEP_WIDTH+1 bits, and KEEP_WIDTH < WIDTH, so WIDTH bits always hold it.
  localparam int LM_M_W       = LM_MAX_WIDTH;

  typedef struct packed {
    logic              zero;
    logic [LM_E_W-1:0] e;
    logic [LM_M_W-1:0] m;
  } s1_payload_t;

endpackage

// File: rtl/antilog_conv_if.sv
// antilog_conv_if: handshake bundle around the antilog stage.
//   in_valid/in_ready   : upstream beat handshake
//   in_sum_k            : summed characteristic k1+k2
//   in_sum_x            : x1_t+x2_t+1; the MSB is the mantissa carry
//   in_zero             : forces a zero product
//   out_valid/out_ready : downstream product handshake
//   out_product         : approximate product, 2*WIDTH bits
// Modport slave is the antilog stage itself. Modport master is its
// environment, which combines the upstream adder and the downstream register.
interface antilog_conv_if #(
  parameter int WIDTH      = 16,
  parameter int KEEP_WIDTH = 5
) ();
  import log_mult_pkg::*;

  localparam int KW = kw_w(WIDTH);
  localparam int PW = prod_w(WIDTH);

  logic                  in_valid;
  logic                  in_ready;
  logic [KW-1:0]         in_sum_k;
  logic [KEEP_WIDTH:0]   in_sum_x;
  logic                  in_zero;
  logic                  out_valid;
  logic                  out_ready;
  logic [PW-1:0]         out_product;

  modport slave (
    input  in_valid, in_sum_k, in_sum_x, in_zero, out_ready,
    output in_ready, out_valid, out_product
  );

  modport master (
    output in_valid, in_sum_k, in_sum_x, in_zero, out_ready,
    input  in_ready, out_valid, out_product
  );

endinterface

// File: rtl/antilog_shift.sv
// antilog_shift: combinational mantissa restoration shifter.
//   m       : restored mantissa {1, f}, zero-extended into the payload field
//   e       : exponent, k plus the mantissa carry
//   product : ((m << e) >> KEEP_WIDTH), keeping the low 2*WIDTH bits.
//             The fractional bits are truncated and not rounded.
module antilog_shift import log_mult_pkg::*; #(
  parameter int WIDTH      = 16,
  parameter int KEEP_WIDTH = 5
) (
  input  logic [LM_M_W-1:0]        m,
  input  logic [LM_E_W-1:0]        e,
  output logic [prod_w(WIDTH)-1:0] product
);

  localparam int PW = prod_w(WIDTH);
  localparam int IW = 2 * WIDTH + KEEP_WIDTH + 1;

  logic [IW-1:0] m_ext;

  always_comb begin
    m_ext   = IW'(m);
    // For legal inputs, no bit above 2*WIDTH-1 is ever set after the shift,
    // so discarding the upper bits loses nothing.
    product = PW'((m_ext << e) >> KEEP_WIDTH);
  end

endmodule

// File: rtl/antilog_conv.sv
// antilog_conv: inverse conversion for the Mitchell log multiplier, built as
// a two-stage valid/ready pipeline.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : antilog_conv_if.slave. It takes in_* beats from the log-domain
//           adder and gives out_* products to the output register.
// Stage 1 splits in_sum_x into the carry and the fraction. It registers
// e = k + c and m = {1, f}. Stage 2 shifts and truncates the product, forces
// it to zero when needed, and registers it.
// Each stage advances when its downstream side can take data, so the pipe
// holds at most 2 beats.
module antilog_conv import log_mult_pkg::*; #(
  parameter int WIDTH      = 16,
  parameter int KEEP_WIDTH = 5
) (
  input logic           clk,
  input logic           rst_n,
  antilog_conv_if.slave bus
);

  localparam int KW = kw_w(WIDTH);
  localparam int PW = prod_w(WIDTH);

  logic                  adv1, adv2;
  logic                  carry;
  logic [KEEP_WIDTH-1:0] frac;
  logic [KW-1:0]         e_in;

  s1_payload_t           s1_d, s1_q;
  logic                  s1_valid_d, s1_valid_q;
  logic                  s2_valid_d, s2_valid_q;
  logic [PW-1:0]         product_d, product_q;
  logic [PW-1:0]         shifted;

  antilog_shift #(
    .WIDTH      (WIDTH),
    .KEEP_WIDTH (KEEP_WIDTH)
  ) u_shift (
    .m       (s1_q.m),
    .e       (s1_q.e),
    .product (shifted)
  );

  always_comb begin
    adv2  = !s2_valid_q || bus.out_ready;
    adv1  = !s1_valid_q || adv2;

    carry = bus.in_sum_x[KEEP_WIDTH];
    frac  = bus.in_sum_x[KEEP_WIDTH-1:0];
    e_in  = bus.in_sum_k + KW'(carry);

    s1_d       = s1_q;
    s1_valid_d = s1_valid_q;
    if (adv1) begin
      s1_valid_d = bus.in_valid;
      s1_d.zero  = bus.in_zero;
      s1_d.e     = LM_E_W'(e_in);
      s1_d.m     = LM_M_W'({1'b1, frac});
    end

    // An empty stage 1 moves into stage 2 as a bubble. The product register
    // may then load unused data, but out_valid stays low.
    product_d  = product_q;
    s2_valid_d = s2_valid_q;
    if (adv2) begin
      s2_valid_d = s1_valid_q;
      product_d  = s1_q.zero ? '0 : shifted;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q       <= '0;
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      product_q  <= '0;
    end else begin
      s1_q       <= s1_d;
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      product_q  <= product_d;
    end
  end

  assign bus.in_ready    = adv1;
  assign bus.out_valid   = s2_valid_q;
  assign bus.out_product = product_q;

endmodule

// File: tb/tb_antilog_conv.sv
// tb_antilog_conv: self-checking bench for antilog_conv (WIDTH=16, KEEP=5).
// Every accepted beat pushes its expected product, computed from the
// arithmetic definition, into a queue. Every output transfer pops the queue
// and compares the product. Directed beats also check fixed literal products
// and the exact latency.
module tb_antilog_conv;

  localparam int W  = 16;
  localparam int KP = 5;

  logic clk;
  logic rst_n;

  antilog_conv_if #(.WIDTH(W), .KEEP_WIDTH(KP)) bus ();

  antilog_conv #(.WIDTH(W), .KEEP_WIDTH(KP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned n_acc = 0;
  int unsigned n_pop = 0;
  logic [31:0] exp_q[$];

  // Reference: value 1.f scaled by 2^(k+c), with the fraction bits truncated.
  function automatic logic [31:0] model(input int k, input int sx, input bit z);
    longint unsigned mant;
    int e;
    if (z) return 32'd0;
    e    = k + (sx / 32);
    mant = 64'd32 + 64'(sx % 32);
    return 32'((mant << e) / 64'd32);
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_beat();
    int k1, k2, x1, x2;
    k1 = $urandom_range(0, 15);
    k2 = $urandom_range(0, 15);
    x1 = $urandom_range(0, 31);
    x2 = $urandom_range(0, 31);
    bus.in_sum_k = 5'(k1 + k2);
    bus.in_sum_x = 6'(x1 + x2 + 1);
    bus.in_zero  = ($urandom_range(0, 7) == 0);
  endtask

  // Scoreboard: the monitor samples on the falling edge, away from the
  // active edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_out_product", 64'(bus.out_product), 64'd0);
      check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        n_pop++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_beat: got %0h expected none", bus.out_product);
        end else begin
          check("stream_product", 64'(bus.out_product), 64'(exp_q.pop_front()));
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        n_acc++;
        exp_q.push_back(model(int'(bus.in_sum_k), int'(bus.in_sum_x), bus.in_zero));
      end
    end
  end

  // Drives one beat into an empty pipe and checks it against a literal
  // expected product. The output must rise after the edge that follows the
  // acceptance edge.
  task automatic directed(input int k, input int sx, input bit z,
                          input logic [31:0] exp, input string nm);
    bus.in_sum_k  = 5'(k);
    bus.in_sum_x  = 6'(sx);
    bus.in_zero   = z;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    check({nm, "_in_ready"}, 64'(bus.in_ready), 64'd1);
    cyc();
    bus.in_valid = 1'b0;
    check({nm, "_lat_early"}, 64'(bus.out_valid), 64'd0);
    cyc();
    check({nm, "_lat_valid"}, 64'(bus.out_valid), 64'd1);
    check(nm, 64'(bus.out_product), 64'(exp));
    cyc();
    check({nm, "_drained"}, 64'(bus.out_valid), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int unsigned a0, p0, prev_acc;
    logic [31:0] p_hold;

    rst_n         = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_sum_k  = 5'd30;
    bus.in_sum_x  = 6'd63;
    bus.in_zero   = 1'b0;
    bus.out_ready = 1'b1;
    repeat (4) cyc();
    rst_n = 1'b1;

    directed(2,  1,  0, 32'd4,         "dir_2x2");
    directed(0,  0,  0, 32'd1,         "dir_one");
    directed(2,  33, 0, 32'd8,         "dir_3x3");
    directed(30, 63, 0, 32'hFC00_0000, "dir_max");
    directed(30, 63, 1, 32'd0,         "dir_zero");

    // Streaming with out_ready held high.
    p0 = n_pop;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      rand_beat();
      bus.in_valid = 1'b1;
      cyc();
    end
    bus.in_valid = 1'b0;
    repeat (2) cyc();
    check("stream_count", 64'(n_pop - p0), 64'd100);
    check("stream_queue_empty", 64'(exp_q.size()), 64'd0);

    // Backpressure.
    a0 = n_acc;
    p0 = n_pop;
    bus.out_ready = 1'b0;
    rand_beat();
    bus.in_valid = 1'b1;
    p_hold = '0;
    for (int i = 0; i < 5; i++) begin
      prev_acc = n_acc;
      cyc();
      if (n_acc != prev_acc) rand_beat();
      if (i == 1) p_hold = bus.out_product;
      if (i >= 2) begin
        check("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
        check("bp_product_stable", 64'(bus.out_product), 64'(p_hold));
      end
    end
    check("bp_accepted", 64'(n_acc - a0), 64'd2);
    check("bp_out_valid", 64'(bus.out_valid), 64'd1);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (4) cyc();
    check("bp_drained", 64'(n_pop - p0), 64'd2);
    check("bp_queue_empty", 64'(exp_q.size()), 64'd0);

    // Random handshakes with a reset in the middle of the run.
    for (int i = 0; i < 300; i++) begin
      rand_beat();
      bus.in_valid  = ($urandom_range(0, 2) != 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      if (i == 150) rst_n = 1'b0;
      if (i == 153) rst_n = 1'b1;
      cyc();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (4) cyc();
    check("rand_queue_empty", 64'(exp_q.size()), 64'd0);
    check("rand_idle", 64'(bus.out_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
